oc_monitor: RTL and testbench

- Over-current front end for the H-bridge driver. It sits directly upstream of the switch block and drives its OC[1:0] input.
- Qualifies two raw comparator lines (one per bridge channel) against the PWM pulse, with leading-edge blanking and glitch filtering.
- Latches a fault per channel and holds it for a cooldown period.
- Releases a fault only on a debounced btnC press once the channel is quiet.

---
 rtl/oc_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/oc_monitor.sv | 169 ++++++++++++++++
 tb/tb_oc_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc_pkg.sv
// Shared types, channel indices and default timing for the over-current monitor.
package oc_pkg;

   localparam int unsigned CLK_HZ              = 100_000_000;
   localparam int unsigned FILTER_CYCLES_DEF   = CLK_HZ / 100_000;
   localparam int unsigned BLANK_CYCLES_DEF    = CLK_HZ / 2_000_000;
   localparam int unsigned COOLDOWN_CYCLES_DEF = CLK_HZ / 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
   localparam int unsigned CNT_W_DEF           = 24;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CH_A   = 0;
   localparam int unsigned CH_B   = 1;

   typedef enum logic [1:0] {StIdle, StQual, StTrip, StArmed} oc_state_e;

   // Saturating add used by the trip counter; never wraps past 255.
   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer, stability filter and single-cycle press pulse generator.
module btn_debounce
   import oc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned    LastI = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] Last = CNT_W'(LastI);

   logic             sync1_q, sync2_q;
   logic             state_q, state_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter runs only while the synced level disagrees with the accepted state.
   always_comb begin
      state_d = state_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != state_q) begin
         if (cnt_q >= Last) begin
            state_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/oc_monitor.sv
// Two-channel over-current qualifier with blanking, glitch filter, fault latch and cooldown.
// Optional build macro OC_AUTO_RETRY_EN enables bounded automatic fault release.
module oc_monitor
   import oc_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES   = FILTER_CYCLES_DEF,
   parameter int unsigned BLANK_CYCLES    = BLANK_CYCLES_DEF,
   parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] comp,
   input  logic       pulse,
   input  logic       btnC,
   output logic [1:0] OC,
   output logic       clr,
   output logic [7:0] fault_count
);

   localparam int unsigned       BlankW    = $clog2(BLANK_CYCLES + 2);
   localparam logic [BlankW-1:0] BlankLoad = BlankW'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0]  FiltLast  = CNT_W'(FILTER_CYCLES);
   localparam logic [CNT_W-1:0]  CoolLoad  = CNT_W'(COOLDOWN_CYCLES);

   logic [1:0]        comp_s1_q, comp_s2_q, samp_comp_q;
   logic              pulse_q, samp_blank_q;
   logic              pulse_rise, blank;
   logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;

   logic [NUM_CH-1:0] valid, trip_now, oc_q;
   logic [CNT_W-1:0]  filt_q   [NUM_CH];
   logic [CNT_W-1:0]  filt_inc [NUM_CH];
   logic [CNT_W-1:0]  cool_q   [NUM_CH];
   oc_state_e         state_q  [NUM_CH];
   logic [1:0]        trip_inc;
   logic [7:0]        fault_cnt_q;
   logic              clr_pulse;
`ifdef OC_AUTO_RETRY_EN
   logic [1:0]        retry_q  [NUM_CH];
`endif

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_btn_debounce (
      .clk_i  (clk),
      .rst_i  (reset),
      .btn_i  (btnC),
      .press_o(clr_pulse)
   );

   // The rise term covers the cycle before the blank counter has loaded.
   always_comb begin
      pulse_rise  = pulse & ~pulse_q;
      blank_cnt_d = blank_cnt_q;
      if (pulse_rise) begin
         blank_cnt_d = BlankLoad;
      end else if (blank_cnt_q != '0) begin
         blank_cnt_d = blank_cnt_q - BlankW'(1);
      end
      blank = pulse_rise | (blank_cnt_q != '0) | ~pulse;
   end

   // Synced comparator level and blank flag are sampled together so they stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         comp_s1_q    <= 2'b00;
         comp_s2_q    <= 2'b00;
         samp_comp_q  <= 2'b00;
         samp_blank_q <= 1'b1;
         pulse_q      <= 1'b0;
         blank_cnt_q  <= '0;
      end else begin
         comp_s1_q    <= comp;
         comp_s2_q    <= comp_s1_q;
         samp_comp_q  <= comp_s2_q;
         samp_blank_q <= blank;
         pulse_q      <= pulse;
         blank_cnt_q  <= blank_cnt_d;
      end
   end

   always_comb begin
      valid    = '0;
      trip_now = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         filt_inc[i] = filt_q[i] + CNT_W'(1);
         valid[i]    = samp_comp_q[i] & ~samp_blank_q;
         trip_now[i] = valid[i] & (filt_inc[i] >= FiltLast) &
                       ((state_q[i] == StIdle) | (state_q[i] == StQual));
      end
      trip_inc = {1'b0, trip_now[CH_A]} + {1'b0, trip_now[CH_B]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            filt_q[i]  <= '0;
            cool_q[i]  <= '0;
            oc_q[i]    <= 1'b0;
`ifdef OC_AUTO_RETRY_EN
            retry_q[i] <= 2'd0;
`endif
         end
         fault_cnt_q <= 8'd0;
      end else begin
         fault_cnt_q <= sat_add8(fault_cnt_q, trip_inc);
         for (int i = 0; i < NUM_CH; i++) begin
            unique case (state_q[i])
               StIdle: begin
                  if (trip_now[i]) begin
                     state_q[i] <= StTrip;
                     oc_q[i]    <= 1'b1;
                     cool_q[i]  <= CoolLoad;
                  end else if (valid[i]) begin
                     state_q[i] <= StQual;
                     filt_q[i]  <= filt_inc[i];
                  end
               end
               StQual: begin
                  if (!samp_comp_q[i]) begin
                     state_q[i] <= StIdle;
                     filt_q[i]  <= '0;
                  end else if (trip_now[i]) begin
                     state_q[i] <= StTrip;
                     filt_q[i]  <= '0;
                     oc_q[i]    <= 1'b1;
                     cool_q[i]  <= CoolLoad;
                  end else if (valid[i]) begin
                     filt_q[i]  <= filt_inc[i];
                  end
               end
               StTrip: begin
                  if (cool_q[i] <= CNT_W'(1)) begin
                     state_q[i] <= StArmed;
                     cool_q[i]  <= '0;
                  end else begin
                     cool_q[i]  <= cool_q[i] - CNT_W'(1);
                  end
               end
               StArmed: begin
                  if (clr_pulse && !samp_comp_q[i]) begin
                     state_q[i] <= StIdle;
                     oc_q[i]    <= 1'b0;
`ifdef OC_AUTO_RETRY_EN
                     retry_q[i] <= 2'd0;
                  end else if (clr_pulse) begin
                     retry_q[i] <= 2'd0;
                  end else if (!samp_comp_q[i] && (retry_q[i] != 2'd3)) begin
                     state_q[i] <= StIdle;
                     oc_q[i]    <= 1'b0;
                     retry_q[i] <= retry_q[i] + 2'd1;
`endif
                  end
               end
               default: state_q[i] <= StIdle;
            endcase
         end
      end
   end

   assign OC          = {oc_q[CH_B], oc_q[CH_A]};
   assign clr         = clr_pulse;
   assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_oc_monitor.sv
// Directed self-checking bench for oc_monitor with shortened timing parameters.
module tb_oc_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] comp;
   logic       pulse;
   logic       btnC;
   logic [1:0] OC;
   logic       clr;
   logic [7:0] fault_count;

   int errors = 0;
   int checks = 0;

   oc_monitor #(
      .FILTER_CYCLES  (4),
      .BLANK_CYCLES   (3),
      .COOLDOWN_CYCLES(20),
      .DEBOUNCE_CYCLES(5),
      .CNT_W          (24)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .comp       (comp),
      .pulse      (pulse),
      .btnC       (btnC),
      .OC         (OC),
      .clr        (clr),
      .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Stops on the negedge where clr is first seen high, or after a bounded wait.
   task automatic wait_clr(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (clr) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; comp = 2'b00; pulse = 1'b0; btnC = 1'b0;
      #1;
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL reset_oc: got %b want 00", OC); end
      checks++;
      if (clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", clr); end
      checks++;
      if (fault_count !== 8'd0) begin
         errors++; $display("FAIL reset_count: got %0d want 0", fault_count);
      end
      cycles(3);
      reset = 1'b0;
      cycles(2);
   endtask

   task automatic test_glitch;
      pulse = 1'b1;
      cycles(10);
      comp = 2'b01;
      cycles(3);
      comp = 2'b00;
      cycles(10);
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL glitch_oc: got %b want 00", OC); end
      checks++;
      if (fault_count !== 8'd0) begin
         errors++; $display("FAIL glitch_count: got %0d want 0", fault_count);
      end
   endtask

   task automatic test_blank_only;
      pulse = 1'b0;
      cycles(4);
      pulse = 1'b1; comp = 2'b01;
      cycles(3);
      comp = 2'b00;
      cycles(12);
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL blank_only_oc: got %b want 00", OC); end
   endtask

   // OC must rise on the 9th clock edge after the pulse rising edge (2 sync + 3 blank + 4 filter).
   task automatic test_trip_blanking;
      pulse = 1'b0;
      cycles(4);
      pulse = 1'b1; comp = 2'b01;
      cycles(8);
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL trip_early: got %b want 00", OC); end
      cycles(1);
      checks++;
      if (OC !== 2'b01) begin errors++; $display("FAIL trip_edge: got %b want 01", OC); end
      checks++;
      if (fault_count !== 8'd1) begin
         errors++; $display("FAIL trip_count: got %0d want 1", fault_count);
      end
   endtask

   task automatic test_clear_gating;
      bit seen;
      int n;
      btnC = 1'b1;
      wait_clr(seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL clr_in_trip: got %b want 1", seen); end
      cycles(2);
      checks++;
      if (OC !== 2'b01) begin errors++; $display("FAIL trip_ignores_clr: got %b want 01", OC); end
      btnC = 1'b0;
      cycles(30);
      btnC = 1'b1;
      wait_clr(seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL clr_comp_high: got %b want 1", seen); end
      cycles(2);
      checks++;
      if (OC !== 2'b01) begin errors++; $display("FAIL armed_comp_high: got %b want 01", OC); end
      btnC = 1'b0;
      cycles(12);
      comp = 2'b00;
      cycles(6);
      btnC = 1'b1;
      wait_clr(seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL clr_comp_low: got %b want 1", seen); end
      checks++;
      if (OC !== 2'b01) begin errors++; $display("FAIL oc_before_release: got %b want 01", OC); end
      cycles(1);
      checks++;
      if (clr !== 1'b0) begin errors++; $display("FAIL clr_width: got %b want 0", clr); end
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL oc_released: got %b want 00", OC); end
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (clr) n++;
      end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL clr_repeat: got %0d pulses want 0", n); end
      btnC = 1'b0;
      cycles(12);
   endtask

   task automatic test_simultaneous;
      bit seen;
      int exp_cnt;
      logic [1:0] first_oc;
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      cycles(8);
      exp_cnt = 0;
      for (int it = 1; it <= 129; it++) begin
         comp = 2'b11;
         first_oc = 2'b00;
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (OC !== 2'b00) begin
               first_oc = OC;
               break;
            end
         end
         exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
         checks++;
         if (first_oc !== 2'b11) begin
            errors++; $display("FAIL sim_oc it=%0d: got %b want 11", it, first_oc);
         end
         checks++;
         if (fault_count !== 8'(exp_cnt)) begin
            errors++; $display("FAIL sim_count it=%0d: got %0d want %0d", it, fault_count, exp_cnt);
         end
         comp = 2'b00;
         cycles(25);
         btnC = 1'b1;
         wait_clr(seen);
         btnC = 1'b0;
         cycles(12);
         checks++;
         if (OC !== 2'b00) begin
            errors++; $display("FAIL sim_clear it=%0d: got %b want 00", it, OC);
         end
      end
   endtask

   task automatic test_async_reset;
      comp = 2'b01;
      cycles(5);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (fault_count !== 8'd0) begin
         errors++; $display("FAIL qual_reset_count: got %0d want 0", fault_count);
      end
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL qual_reset_oc: got %b want 00", OC); end
      @(negedge clk);
      reset = 1'b0;
      cycles(8);
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL post_reset_early: got %b want 00", OC); end
      cycles(1);
      checks++;
      if (OC !== 2'b01) begin errors++; $display("FAIL post_reset_trip: got %b want 01", OC); end
      checks++;
      if (fault_count !== 8'd1) begin
         errors++; $display("FAIL post_reset_count: got %0d want 1", fault_count);
      end
      cycles(3);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL trip_reset_oc: got %b want 00", OC); end
      checks++;
      if (fault_count !== 8'd0) begin
         errors++; $display("FAIL trip_reset_count: got %0d want 0", fault_count);
      end
      comp = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      cycles(10);
      checks++;
      if (OC !== 2'b00) begin errors++; $display("FAIL trip_reset_idle: got %b want 00", OC); end
   endtask

   task automatic test_btn_hold_reset;
      bit seen;
      btnC = 1'b1;
      cycles(15);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      wait_clr(seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL held_btn_clr: got %b want 1", seen); end
      btnC = 1'b0;
      cycles(12);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_blank_only();
      test_trip_blanking();
      test_clear_gating();
      test_simultaneous();
      test_async_reset();
      test_btn_hold_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
